// File: rtl/i2c_cfg_sequencer.sv
// i2c_cfg_sequencer: walks a {sub_addr,data} table and writes each entry as a 3-byte I2C frame, with NACK retry and error flag
module i2c_cfg_sequencer #(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000,
  parameter logic [7:0] DEV_ADDR = 8'h34,
  parameter int LUT_SIZE = 12,
  parameter int IDX_W = 8,
  parameter int MAX_RETRY = 3,
  parameter int AUTO_START = 1,
  parameter int GAP_TICKS = 4
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iSTART,
  input  logic [15:0]      iLUT_DATA,
  output logic [IDX_W-1:0] o_LUT_INDEX,
  output logic             o_BUSY,
  output logic             o_I2C_END,
  output logic             o_ERR,
  output logic [IDX_W-1:0] o_ERR_INDEX,
  output logic             I2C_SCLK,
  inout  wire              I2C_SDAT
);
  localparam int TICK = CLK_FREQ / (4 * I2C_FREQ);
  localparam int DW = TICK > 1 ? $clog2(TICK) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, START, BYTE, STOP, GAP, DONE, ERR} state_t;
  state_t state, nxt;
  logic [DW-1:0] div;
  logic [1:0] q, byte_cnt;
  logic [3:0] bit_cnt, retry;
  logic [7:0] gap_cnt;
  logic [23:0] sr;
  logic nack, armed, sda_oe;
  logic tick, go, last_bit, gap_end;
  logic [IDX_W-1:0] idx_inc;
  assign tick = div == DW'(TICK - 1);
  assign go = iSTART | armed;
  assign last_bit = bit_cnt == 4'd8 && byte_cnt == 2'd2;
  assign gap_end = tick && gap_cnt == 8'(GAP_TICKS - 1);
  assign idx_inc = o_LUT_INDEX + 1'b1;
  assign I2C_SDAT = sda_oe ? 1'b0 : 1'bz;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: nxt = go ? LOAD : state;
      LOAD:  nxt = START;
      START: nxt = tick && q == 2'd3 ? BYTE : state;
      BYTE:  nxt = tick && q == 2'd3 && last_bit ? STOP : state;
      STOP:  nxt = tick && q == 2'd3 ? GAP : state;
      GAP:   nxt = !gap_end ? state :
                   !nack ? (idx_inc == IDX_W'(LUT_SIZE) ? DONE : LOAD) :
                   retry < 4'(MAX_RETRY) ? LOAD : ERR;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      div <= '0;
      q <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      gap_cnt <= '0;
      retry <= '0;
      sr <= '0;
      nack <= 1'b0;
      armed <= 1'(AUTO_START);
      sda_oe <= 1'b0;
      I2C_SCLK <= 1'b1;
      o_LUT_INDEX <= '0;
      o_BUSY <= 1'b0;
      o_I2C_END <= 1'b0;
      o_ERR <= 1'b0;
      o_ERR_INDEX <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      armed <= 1'b0;
      if (tick && state inside {START, BYTE, STOP}) q <= q + 2'd1;
      case (state)
        IDLE, DONE, ERR: if (go) begin
          o_LUT_INDEX <= '0;
          retry <= '0;
          o_BUSY <= 1'b1;
          o_I2C_END <= 1'b0;
          o_ERR <= 1'b0;
        end
        LOAD: begin
          sr <= {DEV_ADDR & 8'hFE, iLUT_DATA};
          nack <= 1'b0;
          q <= '0;
          bit_cnt <= '0;
          byte_cnt <= '0;
        end
        START: if (tick) begin
          if (q == 2'd0) sda_oe <= 1'b1;
          if (q == 2'd2) I2C_SCLK <= 1'b0;
        end
        BYTE: if (tick) begin
          if (q == 2'd0) sda_oe <= bit_cnt == 4'd8 ? 1'b0 : ~sr[23];
          if (q == 2'd1) I2C_SCLK <= 1'b1;
          if (q == 2'd2 && bit_cnt == 4'd8 && I2C_SDAT) nack <= 1'b1;
          if (q == 2'd3) begin
            I2C_SCLK <= 1'b0;
            bit_cnt <= bit_cnt == 4'd8 ? 4'd0 : bit_cnt + 4'd1;
            byte_cnt <= bit_cnt == 4'd8 ? byte_cnt + 2'd1 : byte_cnt;
            sr <= bit_cnt == 4'd8 ? sr : {sr[22:0], 1'b0};
          end
        end
        STOP: if (tick) begin
          if (q == 2'd0) sda_oe <= 1'b1;
          if (q == 2'd1) I2C_SCLK <= 1'b1;
          if (q == 2'd2) sda_oe <= 1'b0;
          if (q == 2'd3) gap_cnt <= '0;
        end
        GAP: if (tick) begin
          gap_cnt <= gap_cnt + 8'd1;
          if (gap_end && !nack) begin
            o_LUT_INDEX <= idx_inc;
            retry <= '0;
            o_I2C_END <= idx_inc == IDX_W'(LUT_SIZE);
            o_BUSY <= idx_inc != IDX_W'(LUT_SIZE);
          end else if (gap_end && retry < 4'(MAX_RETRY)) begin
            retry <= retry + 4'd1;
          end else if (gap_end) begin
            o_ERR <= 1'b1;
            o_ERR_INDEX <= o_LUT_INDEX;
            o_BUSY <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb_i2c_cfg_sequencer: transaction-level frame model plus an I2C slave/bus monitor checking every cycle
module tb_i2c_cfg_sequencer;
  logic clk = 0, rst_n = 0, start = 0;
  always #5 clk = ~clk;
  logic [15:0] lut_data;
  logic [7:0] idx, err_idx;
  logic busy, i2c_end, err, scl;
  logic slave_low = 0;
  wire sda;
  assign sda = slave_low ? 1'b0 : 1'bz;
  pullup (sda);
  logic [15:0] lut [3] = '{16'h1A2B, 16'h3C4D, 16'h5E6F};
  assign lut_data = idx < 8'd3 ? lut[idx[1:0]] : 16'h0;

  i2c_cfg_sequencer #(.CLK_FREQ(400), .I2C_FREQ(25), .DEV_ADDR(8'h34), .LUT_SIZE(3), .IDX_W(8),
    .MAX_RETRY(3), .AUTO_START(1), .GAP_TICKS(4)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iLUT_DATA(lut_data), .o_LUT_INDEX(idx),
    .o_BUSY(busy), .o_I2C_END(i2c_end), .o_ERR(err), .o_ERR_INDEX(err_idx),
    .I2C_SCLK(scl), .I2C_SDAT(sda));

  int n_chk = 0, n_fail = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {int idx; logic [23:0] bytes;} frame_t;
  frame_t exp_q[$];
  int nack_cfg[256];
  int cfg_gen = 0;
  int mon_bits = 0;
  logic exp_end, exp_err;
  int exp_eidx, exp_fidx;

  // Expected frame list and final outcome from the table and the slave's NACK budget
  task automatic plan();
    int i = 0, r = 0;
    int used[256];
    logic nk;
    used = '{default: 0};
    exp_q.delete();
    forever begin
      nk = used[lut[i][15:8]] < nack_cfg[lut[i][15:8]];
      if (nk) used[lut[i][15:8]]++;
      exp_q.push_back('{i, {8'h34, lut[i]}});
      if (!nk) begin
        i++;
        r = 0;
        if (i == 3) begin exp_end = 1; exp_err = 0; exp_fidx = 3; break; end
      end else if (r < 3) r++;
      else begin exp_end = 0; exp_err = 1; exp_eidx = i; exp_fidx = i; break; end
    end
  endtask

  initial begin
    logic ps = 1, pd = 1, inf = 0, hv = 0;
    int hl = 0, gen = 0;
    int att[256];
    logic [23:0] sh = 0;
    frame_t f;
    att = '{default: 0};
    forever @(negedge clk) begin
      if (gen != cfg_gen) begin att = '{default: 0}; gen = cfg_gen; end
      if (!rst_n) begin
        inf = 0; hv = 0; mon_bits = 0; slave_low = 0; ps = scl; pd = sda;
      end else begin
        if (sda !== pd) begin
          chk("sda_edge_with_scl_steady", scl, ps);
          if (scl && ps && !sda) begin
            chk("start_only_when_idle", inf, 0);
            inf = 1; mon_bits = 0; hv = 0; sh = 0;
          end else if (scl && ps) begin
            chk("stop_after_27_bits", mon_bits, 27);
            chk("frame_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              f = exp_q.pop_front();
              chk("frame_bytes", sh, f.bytes);
              chk("frame_index", idx, f.idx);
            end
            inf = 0;
          end
        end
        if (scl && !ps) begin
          hv = inf; hl = 1;
          if (inf && mon_bits < 27) begin
            if (mon_bits % 9 != 8) sh = {sh[22:0], sda};
            mon_bits++;
          end
        end else if (scl && ps) hl++;
        if (!scl && ps) begin
          if (hv) chk("scl_high_cycles", hl, 8);
          hv = 0;
          slave_low = 0;
          if (inf && mon_bits % 9 == 8 && mon_bits < 27) begin
            if (mon_bits == 8) slave_low = sh[7:0] == 8'h34;
            else if (mon_bits == 17 && att[sh[7:0]] < nack_cfg[sh[7:0]]) att[sh[7:0]]++;
            else slave_low = 1;
          end
        end
        if (inf) chk("busy_in_frame", busy, 1);
        ps = scl; pd = sda;
      end
    end
  end

  task automatic wait_end(int budget);
    int n = 0;
    while (!((i2c_end || err) && !busy) && n < budget) begin @(negedge clk); n++; end
    chk("completion_within_budget", n < budget, 1);
  endtask

  task automatic check_end();
    chk("busy_after_run", busy, 0);
    chk("end_flag", i2c_end, exp_end);
    chk("err_flag", err, exp_err);
    if (exp_err) chk("err_index", err_idx, exp_eidx);
    chk("final_index", idx, exp_fidx);
    chk("frames_outstanding", exp_q.size(), 0);
    chk("scl_idle", scl, 1);
    chk("sda_idle", sda, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  initial begin
    nack_cfg = '{default: 0};
    repeat (2) @(negedge clk);
    chk("rst_index", idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_end", i2c_end, 0);
    chk("rst_err", err, 0);
    chk("rst_err_index", err_idx, 0);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    plan();
    chk("model_t1_frames", exp_q.size(), 3);
    chk("model_t1_first", exp_q[0].bytes, 24'h341A2B);
    @(negedge clk) rst_n = 1;
    wait_end(4000);
    check_end();

    nack_cfg[8'h3C] = 1; cfg_gen++;
    plan();
    chk("model_t2_frames", exp_q.size(), 4);
    chk("model_t2_repeat", exp_q[2].idx, 1);
    pulse_start();
    chk("end_drops_on_restart", i2c_end, 0);
    chk("busy_on_restart", busy, 1);
    chk("index_on_restart", idx, 0);
    repeat (700) @(negedge clk);
    chk("busy_mid_sequence", busy, 1);
    pulse_start();
    wait_end(4000);
    check_end();

    nack_cfg[8'h3C] = 0; nack_cfg[8'h5E] = 100; cfg_gen++;
    plan();
    chk("model_t3_frames", exp_q.size(), 6);
    chk("model_t3_err_index", exp_eidx, 2);
    pulse_start();
    wait_end(6000);
    check_end();
    chk("t3_end_low", i2c_end, 0);

    nack_cfg[8'h5E] = 0; cfg_gen++;
    plan();
    pulse_start();
    for (int i = 0; i < 2000 && mon_bits != 10; i++) @(negedge clk);
    chk("reached_bit_10", mon_bits, 10);
    #1 rst_n = 0;
    #1;
    chk("midrst_scl", scl, 1);
    chk("midrst_sda", sda, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_end", i2c_end, 0);
    chk("midrst_err", err, 0);
    chk("midrst_index", idx, 0);
    repeat (3) @(negedge clk);
    plan();
    rst_n = 1;
    wait_end(4000);
    check_end();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
